booth_mult_seq: RTL and testbench

Iterative radix-4 Booth multiplier controller that sequences one `booth_encoder` instance over the 16 Booth groups of a 32-bit signed multiplier. It accumulates the shifted partial products into a 64-bit product. The block sits between the PE issue logic and the writeback path, with a valid/ready handshake on both sides. One multiplication is in flight at a time.

---
 rtl/booth_mult_pkg.sv | 33 +++
 rtl/booth_encoder.sv | 42 ++++
 rtl/booth_mult_seq.sv | 115 +++++++++++
 tb/tb_booth_mult_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
// Optional feature macro: BOOTH_EARLY_TERM_EN (early exit when the
// remaining multiplier groups are all 000 or 111).
package booth_mult_pkg;

   localparam int N_BITS     = 32;
   localparam int NUM_GROUPS = N_BITS / 2;
   localparam int PROD_BITS  = 64;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mult_state_t;

   // Booth group idx of the zero-extended multiplier Bx = {B, 1'b0}
   function automatic logic [2:0] booth_group(input logic [N_BITS:0] bx,
                                              input logic [3:0]      idx);
      return bx[{idx, 1'b0} +: 3];
   endfunction

`ifdef BOOTH_EARLY_TERM_EN
   // True when Bx[32:2*idx] holds a single repeated bit, i.e. every
   // remaining group is 000 or 111 and contributes nothing
   function automatic logic rest_uniform(input logic [N_BITS:0] bx,
                                         input logic [3:0]      idx);
      logic [N_BITS:0] tail;
      tail = $signed(bx) >>> {idx, 1'b0};
      return (&tail) | ~(|tail);
   endfunction
`endif

endpackage

// File: rtl/booth_encoder.sv
// Radix-4 Booth partial-product generator: selects 0, +-A or +-2A for a
// three-bit group and aligns it to bit position 2*group_index_i.
module booth_encoder
   import booth_mult_pkg::*;
(
   input  logic [N_BITS-1:0]    multiplicand_i,
   input  logic [3:0]           group_index_i,
   input  logic [2:0]           group_i,
   output logic [PROD_BITS-1:0] pp_o
);

   logic [PROD_BITS-1:0] a_ext;
   logic [PROD_BITS-1:0] mag;
   logic [PROD_BITS-1:0] term;
   logic                 neg;

   assign a_ext = {{(PROD_BITS-N_BITS){multiplicand_i[N_BITS-1]}}, multiplicand_i};

   // Decode the group into a magnitude/sign, then shift into place
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      mag  = '0;
      neg  = 1'b0;
      term = '0;
      case (group_i)
         3'b001, 3'b010: mag = a_ext;
         3'b011:         mag = a_ext << 1;
         3'b100: begin
            mag = a_ext << 1;
            neg = 1'b1;
         end
         3'b101, 3'b110: begin
            mag = a_ext;
            neg = 1'b1;
         end
         default:        mag = '0;
      endcase
      term = neg ? (~mag + 64'd1) : mag;
      pp_o = term << {group_index_i, 1'b0};
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one booth_encoder stepped over
// the 16 groups of a signed 32-bit multiplier, accumulating a 64-bit
// product. valid/ready on both sides, one multiply in flight.
// Optional feature macro: BOOTH_EARLY_TERM_EN.
module booth_mult_seq
   import booth_mult_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_BITS-1:0]    multiplicand,
   input  logic [N_BITS-1:0]    multiplier,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PROD_BITS-1:0] product,
   output logic                 busy
);

   mult_state_t          state_q, state_d;
   logic [PROD_BITS-1:0] acc_q, acc_d;
   logic [PROD_BITS-1:0] product_q, product_d;
   logic [3:0]           idx_q, idx_d;
   logic [N_BITS-1:0]    a_q, b_q;

   logic [N_BITS:0]      bx;
   logic [2:0]           group;
   logic [PROD_BITS-1:0] pp;
   logic [PROD_BITS-1:0] acc_sum;
   logic                 early_done;
   logic                 accept;

   assign bx      = {b_q, 1'b0};
   assign group   = booth_group(bx, idx_q);
   assign acc_sum = acc_q + pp;
   assign accept  = (state_q == IDLE) && in_valid;

`ifdef BOOTH_EARLY_TERM_EN
   assign early_done = rest_uniform(bx, idx_q);
`else
   assign early_done = 1'b0;
`endif

   booth_encoder u_enc (
      .multiplicand_i (a_q),
      .group_index_i  (idx_q),
      .group_i        (group),
      .pp_o           (pp)
   );

   // Control state and accumulator registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         idx_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         product_q <= product_d;
      end
   end

   // Operand capture on the accepting edge
   always_ff @(posedge clk) begin
      // NOTE: operands carry no reset; they are always loaded on accept before the datapath reads them.
      if (accept) begin
         a_q <= multiplicand;
         b_q <= multiplier;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d   = '0;
               idx_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (early_done) begin
               product_d = acc_q;
               state_d   = DONE;
            end else begin
               acc_d = acc_sum;
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'(NUM_GROUPS - 1)) begin
                  product_d = acc_sum;
                  state_d   = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == BUSY);
   assign out_valid = (state_q == DONE);
   assign product   = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: vector table plus random
// operands through a scoreboard, DONE back-pressure and mid-run reset.
// Honours BOOTH_EARLY_TERM_EN for the expected latency.
module tb_booth_mult_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] exp_q[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
   } vec_t;

   vec_t vecs[9];

   booth_mult_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .busy         (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Clocks from handshake to out_valid, derived bit by bit from the multiplier
   function automatic int exp_latency(input logic [31:0] b);
`ifdef BOOTH_EARLY_TERM_EN
      logic [32:0] bx;
      logic        uni;
      bx = {b, 1'b0};
      for (int k = 0; k < 16; k++) begin
         uni = 1'b1;
         for (int j = 2 * k; j <= 32; j++)
            if (bx[j] != bx[32]) uni = 1'b0;
         if (uni) return k + 1;
      end
`endif
      return 16 + 0 * int'(b[0]);
   endfunction

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      sa = 64'(signed'(a));
      sb = 64'(signed'(b));
      return sa * sb;
   endfunction

   // Drive one operand pair through the handshake; leaves time at E0+1
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
      int w = 0;
      while (!in_ready && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      check("in_ready_before_send", 64'(in_ready), 64'd1);
      in_valid     = 1'b1;
      multiplicand = a;
      multiplier   = b;
      exp_q.push_back(p);
      @(posedge clk); #1;
      in_valid     = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      check("busy_after_accept", 64'(busy), 64'd1);
      check("in_ready_low_busy", 64'(in_ready), 64'd0);
   endtask

   // Wait for the product, check latency and value, then consume it
   task automatic collect(input string name, input int exp_lat);
      int          lat = 0;
      logic [63:0] exp;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("%s_latency", name), 64'(lat), 64'(exp_lat));
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      check($sformatf("%s_product", name), product, exp);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check($sformatf("%s_idle_ready", name), 64'(in_ready), 64'd1);
      check($sformatf("%s_idle_valid", name), 64'(out_valid), 64'd0);
   endtask

   initial begin
      vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
      vecs[1] = '{32'hFFFF_FFF9,  32'h0001_E240,  64'hFFFF_FFFF_FFF2_D040};
      vecs[2] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
      vecs[3] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
      vecs[4] = '{32'h8000_0000,  32'h7FFF_FFFF,  64'hC000_0000_8000_0000};
      vecs[5] = '{32'd5,          32'd0,          64'h0000_0000_0000_0000};
      vecs[6] = '{32'd9,          32'd1,          64'h0000_0000_0000_0009};
      vecs[7] = '{32'd9,          32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFF7};
      vecs[8] = '{32'd3,          32'h4000_0000,  64'h0000_0000_C000_0000};

      rst_n        = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_product", product, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven vectors
      for (int i = 0; i < 9; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].p);
         collect($sformatf("vec%0d", i), exp_latency(vecs[i].b));
      end

      // Random operands, half with small multipliers to vary latency
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 4095));
         send(a, b, model(a, b));
         collect($sformatf("rand%0d", i), exp_latency(b));
      end

      // Back-pressure in DONE: output stable, in_valid ignored
      begin
         int lat = 0;
         send(32'hFFFF_FFFB, 32'd11, 64'hFFFF_FFFF_FFFF_FFC9);
         while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
         end
         check("hold_latency", 64'(lat), 64'(exp_latency(32'd11)));
         for (int i = 0; i < 5; i++) begin
            in_valid     = 1'b1;
            multiplicand = 32'd6;
            multiplier   = 32'd7;
            @(posedge clk); #1;
            check($sformatf("hold%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("hold%0d_product", i), product, 64'hFFFF_FFFF_FFFF_FFC9);
            check($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'd0);
         end
         check("hold_product_pop", product, exp_q.pop_front());
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         check("hold_release_ready", 64'(in_ready), 64'd1);
         check("hold_release_valid", 64'(out_valid), 64'd0);
         exp_q.push_back(64'd42);
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("hold_next_accepted", 64'(busy), 64'd1);
         collect("hold_next", exp_latency(32'd7));
      end

      // Reset in the middle of a multiply at idx=7
      begin
         int seen = 0;
         send(32'd123, 32'h1234_5678, model(32'd123, 32'h1234_5678));
         repeat (7) begin
            @(posedge clk); #1;
         end
         check("pre_reset_busy", 64'(busy), 64'd1);
         rst_n = 1'b0;
         @(posedge clk); #1;
         check("midrst_in_ready", 64'(in_ready), 64'd1);
         check("midrst_out_valid", 64'(out_valid), 64'd0);
         check("midrst_busy", 64'(busy), 64'd0);
         check("midrst_product", product, 64'd0);
         rst_n = 1'b1;
         void'(exp_q.pop_front());
         for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
         end
         check("midrst_no_output", 64'(seen), 64'd0);
         send(32'd2, 32'd2, 64'd4);
         collect("post_reset", exp_latency(32'd2));
      end

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
